// File: rtl/cost_sequencer.sv
// Streams an N-element (activ - answer) gradient and a saturating 0.5*sum(delta^2) loss, one element per cycle.
// Latency: done in the cycle N+2 after the start-accept cycle; start is ignored while busy or in DONE.
module cost_sequencer #(
    parameter int N    = 10,
    parameter int W    = 32,
    parameter int FRAC = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [N*W-1:0]   answers,
    input  logic [N*W-1:0]   activ,
    output logic             busy,
    output logic             done,
    output logic [W-1:0]     loss,
    output logic [N*W-1:0]   nabla_loss
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SCALE,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [N*W-1:0]  act_q, act_d;
    logic [N*W-1:0]  ans_q, ans_d;
    logic [N*W-1:0]  nabla_q, nabla_d;
    logic [W-1:0]    loss_q, loss_d;

    logic signed [W-1:0]   act_i, ans_i, delta;
    logic signed [2*W-1:0] dext, prod;
    logic [W-1:0]          sq;
    logic [W:0]            sum;
    logic [W-1:0]          acc_sum;
    int                    slot;
    logic                  unused_prod_lsb;

    // Single shared subtractor/multiplier datapath for the element at idx_q.
    always_comb begin
        act_i = act_q[int'(idx_q)*W +: W];
        ans_i = ans_q[int'(idx_q)*W +: W];
        delta = act_i - ans_i;
        dext  = {{W{delta[W-1]}}, delta};
        prod  = dext * dext;
        if (|prod[2*W-1:W+FRAC-1]) begin
            sq = {1'b0, {(W-1){1'b1}}};
        end else begin
            sq = {1'b0, prod[W+FRAC-2:FRAC]};
        end
        sum = {1'b0, acc_q} + {1'b0, sq};
        if (|sum[W:W-1]) begin
            acc_sum = {1'b0, {(W-1){1'b1}}};
        end else begin
            acc_sum = sum[W-1:0];
        end
        slot = N - 1 - int'(idx_q);
    end

    assign unused_prod_lsb = ^prod[FRAC-1:0];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        act_d   = act_q;
        ans_d   = ans_q;
        nabla_d = nabla_q;
        loss_d  = loss_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    act_d   = activ;
                    ans_d   = answers;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Element 0 lands in the most significant slot.
                nabla_d[slot*W +: W] = delta;
                acc_d = acc_sum;
                if (idx_q == IW'(N - 1)) begin
                    state_d = SCALE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            SCALE: begin
                loss_d  = acc_q >> 1;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            act_q   <= '0;
            ans_q   <= '0;
            nabla_q <= '0;
            loss_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            act_q   <= act_d;
            ans_q   <= ans_d;
            nabla_q <= nabla_d;
            loss_q  <= loss_d;
        end
    end

    assign busy       = (state_q == RUN) || (state_q == SCALE);
    assign done       = (state_q == DONE);
    assign loss       = loss_q;
    assign nabla_loss = nabla_q;

endmodule
